// File: rtl/data_mem_bfm_pkg.sv
// Shared types, MMIO map and LFSR constants for the data-side memory model.
package data_mem_bfm_pkg;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // MMIO word offsets inside the 64-byte window; 0..3 are the mmreg_corein words
  localparam logic [3:0] OFS_COREOUT_LO = 4'd4;
  localparam logic [3:0] OFS_COREOUT_HI = 4'd5;
  localparam logic [3:0] OFS_ERR_VEC    = 4'd6;
  localparam logic [3:0] OFS_INTR_ACK   = 4'd7;

  typedef enum logic [0:0] {G_IDLE, G_WAIT} gnt_st_e;

  // Command as sampled at grant
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [32:0] wdata;
    logic        err;
  } req_t;

  // Response queue entry; dly counts down to the cycle the response may leave
  typedef struct packed {
    logic [32:0] rdata;
    logic        err;
    logic [3:0]  dly;
  } rsp_t;

  // Uniform-ish draw in 0..wmax from an 8-bit random slice
  function automatic logic [3:0] bounded_draw(input logic [7:0] r, input logic [3:0] wmax);
    logic [8:0] m;
    m = {5'd0, wmax} + 9'd1;
    return 4'(({1'b0, r}) % m);
  endfunction

endpackage

// File: rtl/data_mem_bfm_lfsr.sv
// Free-running Galois LFSR and the bounded latency/error draws taken from it.
module bus_lat_lfsr
  import data_mem_bfm_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2345
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [3:0] gnt_wmax,
  input  logic [3:0] resp_wmax,
  output logic [3:0] gnt_w,
  output logic [3:0] rsp_w,
  output logic [2:0] err_roll
);

  logic [31:0] lfsr_q;

  // Advance one Galois step every cycle; reset reloads the seed
  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) lfsr_q <= SEED;
    else        lfsr_q <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);
  end

  // Fold byte pairs so every state bit feeds some draw
  assign gnt_w    = bounded_draw(lfsr_q[15:8] ^ lfsr_q[7:0], gnt_wmax);
  assign rsp_w    = bounded_draw(lfsr_q[31:24] ^ lfsr_q[23:16], resp_wmax);
  assign err_roll = lfsr_q[2:0];

endmodule

// File: rtl/data_mem_bfm.sv
// Data-side memory model: tagged RAM + MMIO on a req/gnt/rvalid bus with random latency and errors.
module data_mem_bfm
  import data_mem_bfm_pkg::*;
#(
  parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
  parameter int unsigned MEM_AW     = 16,
  parameter logic [31:0] TSMAP_BASE = 32'h8003_0000,
  parameter logic [31:0] MMIO_BASE  = 32'h8F00_0000,
  parameter int unsigned FIFO_D     = 4,
  parameter logic [31:0] SEED       = 32'hACE1_2345
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic [2:0]   ERR_RATE,
  input  logic [3:0]   GNT_WMAX,
  input  logic [3:0]   RESP_WMAX,
  input  logic         err_enable,
  input  logic         data_req,
  input  logic         data_we,
  input  logic [3:0]   data_be,
  input  logic [31:0]  data_addr,
  input  logic [32:0]  data_wdata,
  output logic         data_gnt,
  output logic         data_rvalid,
  output logic [32:0]  data_rdata,
  output logic         data_err,
  input  logic         tsmap_cs,
  input  logic [15:0]  tsmap_addr,
  output logic [31:0]  tsmap_rdata,
  output logic [127:0] mmreg_corein,
  input  logic [63:0]  mmreg_coreout,
  output logic [3:0]   err_enable_vec,
  output logic [2:0]   intr_ack
);

  localparam int unsigned PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int unsigned CW = $clog2(FIFO_D + 1);
  localparam logic [32:0] MEM_END = {1'b0, MEM_BASE} + (33'd1 << (MEM_AW + 2));
  localparam logic [MEM_AW-1:0] TS_IDX0 = MEM_AW'((TSMAP_BASE - MEM_BASE) >> 2);

  logic [32:0] ram [2**MEM_AW];

  gnt_st_e           gst_q, gst_d;
  logic [3:0]        gcnt_q, gcnt_d;
  logic [3:0]        gnt_w, rsp_w;
  logic [2:0]        err_roll;
  logic              full, ram_hit, mmio_hit, rnd_err, ram_we, mmio_we;
  logic [MEM_AW-1:0] ram_idx, ts_idx;
  logic [3:0]        ofs;
  logic [31:0]       mmio_rd;
  logic [32:0]       ram_rd, wr_word, rd_word;
  req_t              acc;
  rsp_t              fifo_q [FIFO_D];
  logic [PW-1:0]     wp_q, rp_q;
  logic [CW-1:0]     cnt_q;
  logic [3:0][31:0]  corein_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_D - 1)) ? '0 : p + 1'b1;
  endfunction

  bus_lat_lfsr #(.SEED(SEED)) u_lat (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .gnt_wmax (GNT_WMAX),
    .resp_wmax(RESP_WMAX),
    .gnt_w    (gnt_w),
    .rsp_w    (rsp_w),
    .err_roll (err_roll)
  );

  assign full = (cnt_q == CW'(FIFO_D));

  // Grant FSM state register
  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      gst_q  <= G_IDLE;
      gcnt_q <= '0;
    end else begin
      gst_q  <= gst_d;
      gcnt_q <= gcnt_d;
    end
  end

  // Grant FSM next state: a fresh wait is drawn on the first req cycle, dropping req aborts it
  always_comb begin
    gst_d  = gst_q;
    gcnt_d = gcnt_q;
    case (gst_q)
      G_IDLE: if (data_req && !(gnt_w == 4'd0 && !full)) begin
        gst_d  = G_WAIT;
        gcnt_d = (gnt_w == 4'd0) ? 4'd0 : gnt_w - 4'd1;
      end
      G_WAIT: begin
        if (!data_req)              gst_d  = G_IDLE;
        else if (gcnt_q == 4'd0) begin
          if (!full)                gst_d  = G_IDLE;
        end else                    gcnt_d = gcnt_q - 4'd1;
      end
      default: gst_d = G_IDLE;
    endcase
  end

  // Grant FSM output: zero-wait grants are combinational from req
  always_comb begin
    data_gnt = 1'b0;
    case (gst_q)
      G_IDLE:  data_gnt = data_req && (gnt_w == 4'd0) && !full;
      G_WAIT:  data_gnt = data_req && (gcnt_q == 4'd0) && !full;
      default: data_gnt = 1'b0;
    endcase
    if (rstn_i) data_gnt = 1'b0;
  end

  // Capture the presented command, decode it and decide its error flag
  always_comb begin
    acc.we    = data_we;
    acc.be    = data_be;
    acc.addr  = data_addr;
    acc.wdata = data_wdata;
    ram_hit   = ({1'b0, acc.addr} >= {1'b0, MEM_BASE}) && ({1'b0, acc.addr} < MEM_END);
    mmio_hit  = (acc.addr[31:6] == MMIO_BASE[31:6]);
    ram_idx   = MEM_AW'((acc.addr - MEM_BASE) >> 2);
    ofs       = acc.addr[5:2];
    rnd_err   = err_enable && (ERR_RATE != 3'd0) && (err_roll < ERR_RATE);
    acc.err   = rnd_err || !(ram_hit || mmio_hit);
  end

  // MMIO read mux; unmapped offsets and the ack register read as zero
  always_comb begin
    mmio_rd = '0;
    if (ofs < OFS_COREOUT_LO)       mmio_rd = corein_q[ofs[1:0]];
    else if (ofs == OFS_COREOUT_LO) mmio_rd = mmreg_coreout[31:0];
    else if (ofs == OFS_COREOUT_HI) mmio_rd = mmreg_coreout[63:32];
    else if (ofs == OFS_ERR_VEC)    mmio_rd = {28'd0, err_enable_vec};
  end

  // Byte-merge for writes and read data snapshot taken at grant
  always_comb begin
    ram_rd  = ram[ram_idx];
    wr_word = ram_rd;
    for (int b = 0; b < 4; b++)
      if (acc.be[b]) wr_word[8*b +: 8] = acc.wdata[8*b +: 8];
    wr_word[32] = (acc.be == 4'hF) ? acc.wdata[32] : 1'b0;
    rd_word = '0;
    if (!acc.we && !acc.err) rd_word = ram_hit ? ram_rd : {1'b0, mmio_rd};
  end

  assign ram_we  = data_gnt && acc.we && ram_hit  && !acc.err;
  assign mmio_we = data_gnt && acc.we && mmio_hit && !acc.err;

  // RAM write port; contents deliberately survive reset
  always_ff @(posedge clk_i) begin
    if (ram_we) ram[ram_idx] <= wr_word;
  end

  // Tag-safety map read port, independent of the bus side
  assign ts_idx = TS_IDX0 + MEM_AW'(tsmap_addr);
  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i)        tsmap_rdata <= '0;
    else if (tsmap_cs) tsmap_rdata <= ram[ts_idx][31:0];
  end

  // MMIO registers; intr_ack is a single-cycle pulse
  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      corein_q       <= '0;
      err_enable_vec <= '0;
      intr_ack       <= '0;
    end else begin
      intr_ack <= '0;
      if (mmio_we) begin
        if (ofs < OFS_COREOUT_LO) begin
          for (int b = 0; b < 4; b++)
            if (acc.be[b]) corein_q[ofs[1:0]][8*b +: 8] <= acc.wdata[8*b +: 8];
        end else if (ofs == OFS_ERR_VEC) begin
          if (acc.be[0]) err_enable_vec <= acc.wdata[3:0];
        end else if (ofs == OFS_INTR_ACK) begin
          if (acc.be[0]) intr_ack <= acc.wdata[2:0];
        end
      end
    end
  end

  assign mmreg_corein = corein_q;

  // In-order response queue: every entry counts down, only the head may leave
  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < FIFO_D; i++) fifo_q[i] <= '0;
    end else begin
      for (int i = 0; i < FIFO_D; i++)
        if (fifo_q[i].dly != 4'd0) fifo_q[i].dly <= fifo_q[i].dly - 4'd1;
      if (data_gnt) begin
        fifo_q[wp_q] <= '{rdata: rd_word, err: acc.err, dly: rsp_w};
        wp_q         <= ptr_inc(wp_q);
      end
      if (data_rvalid) rp_q <= ptr_inc(rp_q);
      cnt_q <= cnt_q + CW'(data_gnt) - CW'(data_rvalid);
    end
  end

  assign data_rvalid = (cnt_q != '0) && (fifo_q[rp_q].dly == 4'd0);
  assign data_rdata  = data_rvalid ? fifo_q[rp_q].rdata : '0;
  assign data_err    = data_rvalid && fifo_q[rp_q].err;

endmodule

// File: tb/tb_data_mem_bfm.sv
// Scoreboard bench for data_mem_bfm: driver pushes expectations at grant, monitor checks at rvalid.
module tb_data_mem_bfm;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic [2:0]   err_rate;
  logic [3:0]   gnt_wmax, resp_wmax;
  logic         err_enable, data_req, data_we;
  logic [3:0]   data_be;
  logic [31:0]  data_addr;
  logic [32:0]  data_wdata;
  logic         data_gnt, data_rvalid, data_err;
  logic [32:0]  data_rdata;
  logic         tsmap_cs;
  logic [15:0]  tsmap_addr;
  logic [31:0]  tsmap_rdata;
  logic [127:0] mmreg_corein;
  logic [63:0]  mmreg_coreout;
  logic [3:0]   err_enable_vec;
  logic [2:0]   intr_ack;

  data_mem_bfm dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .ERR_RATE(err_rate), .GNT_WMAX(gnt_wmax),
    .RESP_WMAX(resp_wmax), .err_enable(err_enable), .data_req(data_req), .data_we(data_we),
    .data_be(data_be), .data_addr(data_addr), .data_wdata(data_wdata), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata), .data_err(data_err),
    .tsmap_cs(tsmap_cs), .tsmap_addr(tsmap_addr), .tsmap_rdata(tsmap_rdata),
    .mmreg_corein(mmreg_corein), .mmreg_coreout(mmreg_coreout),
    .err_enable_vec(err_enable_vec), .intr_ack(intr_ack)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [32:0] d;
    bit          e;
    bit          e_any;
    int          t;
  } exp_t;

  exp_t        sb[$];
  exp_t        mx;
  int          checks = 0, failures = 0, cyc = 0;
  int          n_gnt = 0, n_rsp = 0, n_err = 0, max_out = 0, ack_pulses = 0, dly;
  logic [2:0]  ack_val = '0;
  logic [32:0] mdl [16];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp_v);
    end
  endtask

  task automatic chk_rng(input string nm, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      failures++;
      $display("FAIL %s got=%0d expected_range=%0d..%0d", nm, v, lo, hi);
    end
  endtask

  always @(posedge clk_i) cyc++;

  // Response monitor
  always @(negedge clk_i) begin
    if (!rstn_i && data_rvalid) begin
      n_rsp++;
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_rvalid got=%0h expected=none", data_rdata);
      end else begin
        mx  = sb.pop_front();
        dly = cyc - mx.t;
        chk_rng("rsp_delay", dly, 1, int'(resp_wmax) + 1);
        if (mx.e_any) begin
          if (data_err) begin
            n_err++;
            chk("err_rdata", data_rdata, 33'h0);
          end else chk("rdata", data_rdata, mx.d);
        end else begin
          chk("rdata", data_rdata, mx.d);
          chk("err", data_err, mx.e);
        end
      end
    end
  end

  // Interrupt-acknowledge pulse observer
  always @(negedge clk_i) begin
    if (!rstn_i && intr_ack != 3'b0) begin
      ack_pulses++;
      ack_val = intr_ack;
    end
  end

  // Issue one request (called at posedge+1), hold until granted, queue its expectation
  task automatic bus(input logic we, input logic [3:0] be, input logic [31:0] addr,
                     input logic [32:0] wd, input logic [32:0] exp_d, input bit exp_e,
                     input bit e_any);
    int   w;
    bit   got;
    exp_t x;
    w = 0; got = 0;
    data_req = 1'b1; data_we = we; data_be = be; data_addr = addr; data_wdata = wd;
    forever begin
      @(negedge clk_i);
      if (data_gnt) begin got = 1; break; end
      w++;
      if (w > 64) break;
      @(posedge clk_i); #1;
    end
    if (got) begin
      chk_rng("gnt_wait", w, 0, int'(gnt_wmax));
      x.d = exp_d; x.e = exp_e; x.e_any = e_any; x.t = cyc;
      sb.push_back(x);
      n_gnt++;
      if (sb.size() > max_out) max_out = sb.size();
    end else begin
      checks++; failures++;
      $display("FAIL gnt_timeout waited=%0d limit=64", w);
    end
    @(posedge clk_i); #1;
    data_req = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(posedge clk_i); #1;
      k++;
    end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout pending=%0d expected=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time_limit_reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int          i, k, n0;
    logic [3:0]  be;
    logic [32:0] wd;
    rstn_i = 1'b1; err_rate = 3'd0; gnt_wmax = 4'd0; resp_wmax = 4'd0; err_enable = 1'b0;
    data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h8000_0010; data_wdata = '0;
    tsmap_cs = 1'b0; tsmap_addr = '0; mmreg_coreout = 64'h1234_5678_9ABC_DEF0;

    // Reset state (req held high to show grant is suppressed)
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_gnt", data_gnt, 1'b0);
    chk("rst_rvalid", data_rvalid, 1'b0);
    chk("rst_rdata", data_rdata, 33'h0);
    chk("rst_err", data_err, 1'b0);
    chk("rst_tsmap", tsmap_rdata, 32'h0);
    chk("rst_corein", mmreg_corein, 128'h0);
    chk("rst_errvec", err_enable_vec, 4'h0);
    chk("rst_ack", intr_ack, 3'h0);
    data_req = 1'b0;
    @(posedge clk_i); #1 rstn_i = 1'b0;
    @(posedge clk_i); #1;

    // Zero-latency full write then read; partial write clears tag
    bus(1, 4'hF, 32'h8000_0010, 33'h1_DEAD_BEEF, 33'h0, 0, 0);
    bus(0, 4'hF, 32'h8000_0010, 33'h0, 33'h1_DEAD_BEEF, 0, 0);
    bus(1, 4'b0010, 32'h8000_0010, 33'h0_0000_AB00, 33'h0, 0, 0);
    bus(0, 4'hF, 32'h8000_0010, 33'h0, 33'h0_DEAD_ABEF, 0, 0);
    drain();

    // MMIO
    bus(1, 4'hF, 32'h8F00_0018, 33'h5, 33'h0, 0, 0);
    drain();
    chk("errvec", err_enable_vec, 4'h5);
    ack_pulses = 0;
    bus(1, 4'hF, 32'h8F00_001C, 33'h2, 33'h0, 0, 0);
    drain();
    repeat (3) @(posedge clk_i); #1;
    chk("ack_pulses", ack_pulses, 1);
    chk("ack_val", ack_val, 3'b010);
    bus(0, 4'hF, 32'h8F00_0010, 33'h0, 33'h0_9ABC_DEF0, 0, 0);
    bus(0, 4'hF, 32'h8F00_0014, 33'h0, 33'h0_1234_5678, 0, 0);
    bus(1, 4'hF, 32'h8F00_0004, 33'h1_CAFE_F00D, 33'h0, 0, 0);
    bus(0, 4'hF, 32'h8F00_0004, 33'h0, 33'h0_CAFE_F00D, 0, 0);
    bus(0, 4'hF, 32'h8F00_001C, 33'h0, 33'h0, 0, 0);
    bus(0, 4'hF, 32'h8F00_0018, 33'h0, 33'h0_0000_0005, 0, 0);
    drain();
    chk("corein", mmreg_corein, 128'h0000_0000_0000_0000_CAFE_F00D_0000_0000);

    // tsmap port
    bus(1, 4'hF, 32'h8003_0008, 33'h0_0000_55AA, 33'h0, 0, 0);
    drain();
    tsmap_cs = 1'b1; tsmap_addr = 16'd2;
    @(posedge clk_i); #1 tsmap_cs = 1'b0; tsmap_addr = 16'd5;
    @(negedge clk_i);
    chk("tsmap", tsmap_rdata, 32'h0000_55AA);
    @(negedge clk_i);
    chk("tsmap_hold", tsmap_rdata, 32'h0000_55AA);
    @(posedge clk_i); #1;

    // Decode boundaries and unmapped accesses
    bus(1, 4'hF, 32'h8003_FFFC, 33'h1_0BAD_F00D, 33'h0, 0, 0);
    bus(0, 4'hF, 32'h8003_FFFC, 33'h0, 33'h1_0BAD_F00D, 0, 0);
    bus(0, 4'hF, 32'h9000_0000, 33'h0, 33'h0, 1, 0);
    bus(1, 4'hF, 32'h9000_0000, 33'h1_FFFF_FFFF, 33'h0, 1, 0);
    bus(0, 4'hF, 32'h8004_0000, 33'h0, 33'h0, 1, 0);
    bus(0, 4'hF, 32'h7FFF_FFFC, 33'h0, 33'h0, 1, 0);
    bus(0, 4'hF, 32'h8F00_0040, 33'h0, 33'h0, 1, 0);
    drain();

    // Random latency with a small reference model
    gnt_wmax = 4'd7; resp_wmax = 4'd7;
    for (i = 0; i < 16; i++) begin
      mdl[i] = {1'($urandom_range(0, 1)), $urandom};
      bus(1, 4'hF, 32'h8000_1000 + 32'(4*i), mdl[i], 33'h0, 0, 0);
    end
    for (int n = 0; n < 200; n++) begin
      k = 0;
      while (sb.size() >= 3 && k < 100) begin @(posedge clk_i); #1; k++; end
      i = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        be = 4'($urandom_range(0, 15));
        wd = {1'($urandom_range(0, 1)), $urandom};
        for (int b = 0; b < 4; b++) if (be[b]) mdl[i][8*b +: 8] = wd[8*b +: 8];
        mdl[i][32] = (be == 4'hF) ? wd[32] : 1'b0;
        bus(1, be, 32'h8000_1000 + 32'(4*i), wd, 33'h0, 0, 0);
      end else begin
        bus(0, 4'hF, 32'h8000_1000 + 32'(4*i), 33'h0, mdl[i], 0, 0);
      end
    end
    drain();
    chk("count_match", n_rsp, n_gnt);
    chk_rng("max_outstanding", max_out, 1, 4);

    // Error injection
    gnt_wmax = 4'd0; resp_wmax = 4'd0; err_rate = 3'd4; err_enable = 1'b1; n_err = 0;
    for (int n = 0; n < 1000; n++) bus(0, 4'hF, 32'h8000_0010, 33'h0, 33'h0_DEAD_ABEF, 0, 1);
    drain();
    chk_rng("err_rate4_count", n_err, 300, 700);
    err_enable = 1'b0;
    for (int n = 0; n < 30; n++) bus(0, 4'hF, 32'h8000_0010, 33'h0, 33'h0_DEAD_ABEF, 0, 0);
    err_rate = 3'd0; err_enable = 1'b1;
    for (int n = 0; n < 30; n++) bus(0, 4'hF, 32'h8000_0010, 33'h0, 33'h0_DEAD_ABEF, 0, 0);
    drain();
    err_enable = 1'b0;

    // Reset with responses in flight: nothing may come out afterwards
    resp_wmax = 4'd15;
    bus(0, 4'hF, 32'h8000_0010, 33'h0, 33'h0_DEAD_ABEF, 0, 0);
    bus(0, 4'hF, 32'h8000_0010, 33'h0, 33'h0_DEAD_ABEF, 0, 0);
    bus(0, 4'hF, 32'h8000_0010, 33'h0, 33'h0_DEAD_ABEF, 0, 0);
    @(negedge clk_i); #1;
    rstn_i = 1'b1;
    sb.delete();
    n0 = n_rsp;
    repeat (5) @(posedge clk_i);
    #1 rstn_i = 1'b0;
    repeat (25) @(posedge clk_i); #1;
    chk("midrst_no_rvalid", n_rsp, n0);
    chk("midrst_errvec", err_enable_vec, 4'h0);
    resp_wmax = 4'd0;
    bus(0, 4'hF, 32'h8000_0010, 33'h0, 33'h0_DEAD_ABEF, 0, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
